// File: rtl/serdes_seq_pkg.sv
// Shared types and constants for the serializer link sequencer.
// No logic: state encoding, default words and the PRBS seed.
// No handshake of its own.
package serdes_seq_pkg;

   typedef logic [9:0] word_t;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_TRAIN = 2'd2,
      ST_RUN   = 2'd3
   } seq_state_e;

   localparam word_t      IDLE_WORD_DEF  = 10'h354;
   localparam word_t      TRAIN_WORD_DEF = 10'h0F8;
   localparam logic [6:0] PRBS_SEED      = 7'h7F;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/serdes_link_sequencer_if.sv
// Requester-side bundle: control and data word streams into the sequencer.
// Combinational: readies follow the valids within the same cycle.
// Valid/ready; a word is taken only in a cycle where both are high.
interface serdes_link_sequencer_if;
   import serdes_seq_pkg::*;

   word_t c_data_i;
   logic  c_valid_i;
   logic  c_ready_o;
   word_t d_data_i;
   logic  d_valid_i;
   logic  d_ready_o;

   modport master (output c_data_i, c_valid_i, d_data_i, d_valid_i,
                   input  c_ready_o, d_ready_o);
   modport slave  (input  c_data_i, c_valid_i, d_data_i, d_valid_i,
                   output c_ready_o, d_ready_o);
endinterface

// File: rtl/serdes_link_sequencer_prbs7.sv
// PRBS7 (x^7+x^6+1) word generator, 10 bits per step LSB first (SEQ_PRBS_TRAIN_EN only).
// Word is combinational from the LFSR state; the state moves on the next edge.
// No backpressure: load wins over advance, otherwise it holds.
`ifdef SEQ_PRBS_TRAIN_EN
module prbs7_word_gen
   import serdes_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load_i,
   input  logic [6:0] seed_i,
   input  logic       advance_i,
   output word_t      word_o
);
   logic [6:0] lfsr_q, lfsr_d, walk;
   logic       fb;

   always_comb begin
      walk   = lfsr_q;
      fb     = 1'b0;
      word_o = '0;
      for (int j = 0; j < 10; j++) begin
         fb        = walk[6] ^ walk[5];
         word_o[j] = fb;
         walk      = {walk[5:0], fb};
      end
      lfsr_d = load_i ? seed_i : (advance_i ? walk : lfsr_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) lfsr_q <= PRBS_SEED;
      else          lfsr_q <= lfsr_d;
   end
endmodule
`endif

// File: rtl/serdes_link_sequencer.sv
// Lane sequencer: OFF/HOLD/TRAIN/RUN in front of the OSERDES, then control/data arbitration (PRBS training with SEQ_PRBS_TRAIN_EN).
// Granted word reaches p_data_o one cycle after its handshake; status outputs lag the state by one cycle.
// Readies are low outside RUN; data can stall control only after CTRL_BURST back-to-back control grants.
module serdes_link_sequencer
   import serdes_seq_pkg::*;
#(
   parameter int    RST_HOLD    = 16,
   parameter int    TRAIN_WORDS = 1024,
   parameter int    CTRL_BURST  = 4,
   parameter word_t IDLE_WORD   = IDLE_WORD_DEF,
   parameter word_t TRAIN_WORD  = TRAIN_WORD_DEF
)(
   input  logic                    clk_i,
   input  logic                    a_rst_n_i,
   input  logic                    enable_i,
   input  logic                    retrain_i,
   serdes_link_sequencer_if.slave  req,
   output word_t                   p_data_o,
   output logic                    serdes_rst_n_o,
   output logic                    link_up_o,
   output logic [1:0]              state_o
);
   localparam int CW = $clog2(max2(RST_HOLD, TRAIN_WORDS) + 1);
   localparam int BW = $clog2(CTRL_BURST + 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);
   localparam logic [BW-1:0] BURST_MAX  = BW'(CTRL_BURST);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] burst_q, burst_d;
   word_t         p_data_q, p_data_d, train_word;
   logic          srst_q, srst_d, link_q, link_d;
   logic          run, c_grant, d_grant;

   always_ff @(posedge clk_i) begin
      if (!a_rst_n_i) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Disable beats retrain, retrain beats the terminal-count transitions.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable_i) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else if (retrain_i && (state_q == ST_TRAIN || state_q == ST_RUN)) begin
         state_d = ST_TRAIN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = ST_TRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_TRAIN: begin
               if (cnt_q == TRAIN_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_PRBS_TRAIN_EN
   logic train_load;
   assign train_load = (state_d == ST_TRAIN) && (state_q != ST_TRAIN || retrain_i);

   prbs7_word_gen u_prbs (
      .clk_i     (clk_i),
      .rst_n_i   (a_rst_n_i),
      .load_i    (train_load),
      .seed_i    (PRBS_SEED),
      .advance_i (state_q == ST_TRAIN),
      .word_o    (train_word)
   );
`else
   assign train_word = TRAIN_WORD;
`endif

   always_comb begin
      run           = (state_q == ST_RUN);
      req.c_ready_o = run && !(req.d_valid_i && burst_q == BURST_MAX);
      req.d_ready_o = run && req.d_valid_i && !(req.c_valid_i && req.c_ready_o);
      c_grant       = req.c_valid_i && req.c_ready_o;
      d_grant       = req.d_ready_o;

      burst_d = burst_q;
      if (d_grant || !req.d_valid_i)
         burst_d = '0;
      else if (c_grant && burst_q != BURST_MAX)
         burst_d = burst_q + 1'b1;

      case (state_q)
         ST_TRAIN: p_data_d = train_word;
         ST_RUN:   p_data_d = c_grant ? req.c_data_i : (d_grant ? req.d_data_i : IDLE_WORD);
         default:  p_data_d = IDLE_WORD;
      endcase
      srst_d = (state_q == ST_TRAIN) || run;
      link_d = run;
   end

   always_ff @(posedge clk_i) begin
      if (!a_rst_n_i) begin
         p_data_q <= IDLE_WORD;
         srst_q   <= 1'b0;
         link_q   <= 1'b0;
         burst_q  <= '0;
      end else begin
         p_data_q <= p_data_d;
         srst_q   <= srst_d;
         link_q   <= link_d;
         burst_q  <= burst_d;
      end
   end

   assign p_data_o       = p_data_q;
   assign serdes_rst_n_o = srst_q;
   assign link_up_o      = link_q;
   assign state_o        = state_q;
endmodule
